jmpctl: RTL
===========

# jmpctl

Parametrised next-PC / branch-resolution unit for the N-queen sequencer. Each enabled cycle it samples the decoded opcode and ALU result, decides whether control flow leaves the sequential path, and issues a registered PC load (`pc_in`, `pc_we`) to the program counter. Beyond unconditional jumps and flag-qualified CHECK/SUPERCHECK branches, it adds a not-zero branch and CALL/RET through an internal return-address stack of configurable depth, with sticky overflow/underflow flags.

## Interface
- `AW`, 6, PC / jump-address width.
- `DW`, 8, ALU result width.
- `OPW`, 4, opcode width.
- `DEPTH`, 4, return-stack entries (≥1).
- `OP_JUMP`, 4'd1, unconditional jump encoding.
- `OP_CHECK`, 4'd2, branch-if-`alu_out`==1 encoding.
- `OP_SUPERCHECK`, 4'd3, branch-if-`alu_out`==1 encoding.
- `OP_JNZ`, 4'd4, branch-if-`alu_out`!=0 encoding.
- `OP_CALL`, 4'd5, call encoding.
- `OP_RET`, 4'd6, return encoding.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — asynchronous, active-low reset.
- `en` in 1 — evaluate this cycle; 0 = stall.
- `alu_op` in OPW — decoded opcode.
- `alu_out` in DW — ALU result for the same instruction.
- `jmp_addr` in AW — branch/call target.
- `pc_cur` in AW — PC of the current instruction.
- `err_clr` in 1 — clears `ovf`/`unf`.
- `pc_in` out AW — PC load value.
- `pc_we` out 1 — PC load strobe.
- `sp` out clog2(DEPTH+1) — number of valid stack entries.
- `ovf` out 1 — sticky: CALL attempted with stack full.
- `unf` out 1 — sticky: RET attempted with stack empty.

## Operation
- All outputs are registered. Reset (`rst`=0) asynchronously sets `pc_in`=0, `pc_we`=0, `sp`=0, `ovf`=0, `unf`=0, and all stack entries to 0.
- If `en`=0 on an edge: `pc_in`=0, `pc_we`=0, stack and `sp` unchanged, flags unchanged except via `err_clr`.
- If `en`=1, the unit decodes `alu_op`:
  - JUMP: `pc_in`=`jmp_addr`, `pc_we`=1.
  - CHECK / SUPERCHECK: taken iff the full DW-bit `alu_out`==1. Any other value, including 3 or 0x81, is not taken.
  - JNZ: taken iff `alu_out`!=0.
  - CALL with `sp`<DEPTH: push (`pc_cur`+1) mod 2^AW, `sp`+1, `pc_in`=`jmp_addr`, `pc_we`=1.
  - CALL with `sp`==DEPTH: no push, `pc_we`=0, `pc_in`=0, `ovf`←1.
  - RET with `sp`>0: `pc_in`=top entry, `sp`−1, `pc_we`=1.
  - RET with `sp`==0: `pc_we`=0, `pc_in`=0, `unf`←1.
  - Not taken or unknown opcode: `pc_in`=0, `pc_we`=0.
- Stack is LIFO, indexed by `sp`. Popped entries need not be cleared.
- `err_clr`=1 clears both flags. If a new error occurs on the same edge, that flag is set; set wins over clear. `err_clr` does not depend on `en`.
- `alu_out` is ignored for JUMP, CALL and RET.

## Timing
- Latency is 1 cycle: the op sampled at edge N drives `pc_in`/`pc_we` from edge N until edge N+1.
- `pc_we` is a single-cycle pulse per taken op. Back-to-back taken ops produce consecutive pulses.
- One op per cycle. CALL then RET on consecutive cycles returns the just-pushed address. Stack update and `sp` are visible from the next edge.
- Reset asserted mid-operation empties the stack immediately. The first edge after `rst` deasserts evaluates normally.
- `pc_in` is always 0 whenever `pc_we`=0.

## Test plan
- Reset, then JUMP `jmp_addr`=0x2A with `en`=1 → next cycle `pc_in`=0x2A, `pc_we`=1; following idle cycle `pc_in`=0, `pc_we`=0.
- CHECK with `alu_out`=1 → `pc_we`=1. CHECK with `alu_out`=0x03 → `pc_we`=0. JNZ with 0x80 → taken. JNZ with 0 → not taken.
- CALL ×4 (`pc_cur`=0x10,0x20,0x30,0x3F; DEPTH=4) → `sp`=4, then RET ×4 → `pc_in`=0x00 (wrap from 0x3F), then 0x31, 0x21, 0x11; `sp`=0.
- 5th CALL at `sp`=4 → `pc_we`=0, `ovf`=1, `sp`=4. RET at `sp`=0 → `unf`=1. `err_clr` on the same edge as a new underflow → `unf` stays 1. `err_clr` alone → both 0.
- JUMP with `en`=0 → no `pc_we`. CALL with `en`=0 → `sp` unchanged.
- Push 2 entries, pulse `rst` low between edges → `sp`=0 and outputs 0 immediately. A following RET → `unf`=1.

Source files
------------

// File: rtl/jmpctl_if.sv
// -----------------------------------------------------------------------------
// jmpctl_if
// Bundle of signals between the decode stage / program counter and the jmpctl
// next-PC unit.
//   master : drives the decoded instruction (en, alu_op, alu_out, jmp_addr,
//            pc_cur, err_clr) and observes the PC load and stack status.
//   slave  : the jmpctl unit itself.
// Widths follow the same parameters as jmpctl and must match its instance.
// -----------------------------------------------------------------------------
interface jmpctl_if #(
    parameter int AW    = 6,
    parameter int DW    = 8,
    parameter int OPW   = 4,
    parameter int DEPTH = 4
);
    localparam int SPW = $clog2(DEPTH + 1);

    logic           en;
    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_out;
    logic [AW-1:0]  jmp_addr;
    logic [AW-1:0]  pc_cur;
    logic           err_clr;

    logic [AW-1:0]  pc_in;
    logic           pc_we;
    logic [SPW-1:0] sp;
    logic           ovf;
    logic           unf;

    modport master (
        output en, alu_op, alu_out, jmp_addr, pc_cur, err_clr,
        input  pc_in, pc_we, sp, ovf, unf
    );

    modport slave (
        input  en, alu_op, alu_out, jmp_addr, pc_cur, err_clr,
        output pc_in, pc_we, sp, ovf, unf
    );
endinterface

// File: rtl/jmpctl.sv
// -----------------------------------------------------------------------------
// jmpctl
// Next-PC / branch-resolution unit. Each enabled cycle it decodes the opcode
// and ALU result and issues a registered, single-cycle PC load. Supports
// unconditional JUMP, CHECK/SUPERCHECK (taken iff alu_out == 1), JNZ
// (taken iff alu_out != 0) and CALL/RET through a DEPTH-entry return stack
// with sticky overflow/underflow flags.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - jmpctl_if slave: en, alu_op, alu_out, jmp_addr, pc_cur, err_clr in;
//          pc_in, pc_we, sp, ovf, unf out (all outputs registered)
// -----------------------------------------------------------------------------
module jmpctl #(
    parameter int             AW            = 6,
    parameter int             DW            = 8,
    parameter int             OPW           = 4,
    parameter int             DEPTH         = 4,
    parameter logic [OPW-1:0] OP_JUMP       = OPW'(1),
    parameter logic [OPW-1:0] OP_CHECK      = OPW'(2),
    parameter logic [OPW-1:0] OP_SUPERCHECK = OPW'(3),
    parameter logic [OPW-1:0] OP_JNZ        = OPW'(4),
    parameter logic [OPW-1:0] OP_CALL       = OPW'(5),
    parameter logic [OPW-1:0] OP_RET        = OPW'(6)
) (
    input  logic     clk,
    input  logic     rst,
    jmpctl_if.slave  bus
);
    localparam int SPW = $clog2(DEPTH + 1);

    logic [AW-1:0]  pc_in_reg, pc_in_next;
    logic           pc_we_reg, pc_we_next;
    logic [SPW-1:0] sp_reg,    sp_next;
    logic           ovf_reg,   ovf_next;
    logic           unf_reg,   unf_next;

    logic           push;
    logic           ovf_set;
    logic           unf_set;
    logic [AW-1:0]  ret_addr;
    logic [AW-1:0]  top_entry;
    logic [AW-1:0]  stack_q [DEPTH];

    logic stack_full;
    logic stack_empty;

    assign stack_full  = (sp_reg == SPW'(DEPTH));
    assign stack_empty = (sp_reg == '0);

    // Return address wraps naturally at 2^AW.
    assign ret_addr = bus.pc_cur + AW'(1);

    // Return stack: entry gi is written when a push lands at depth gi.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stack
        logic [AW-1:0] entry_reg;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                entry_reg <= '0;
            end else if (push && (sp_reg == SPW'(gi))) begin
                entry_reg <= ret_addr;
            end
        end

        assign stack_q[gi] = entry_reg;
    end

    // Top of stack lives at index sp-1.
    always_comb begin
        top_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp_reg == SPW'(i + 1)) begin
                top_entry = stack_q[i];
            end
        end
    end

    always_comb begin
        pc_in_next = '0;
        pc_we_next = 1'b0;
        sp_next    = sp_reg;
        push       = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;

        if (bus.en) begin
            if (bus.alu_op == OP_JUMP) begin
                pc_in_next = bus.jmp_addr;
                pc_we_next = 1'b1;
            end else if (bus.alu_op == OP_CHECK || bus.alu_op == OP_SUPERCHECK) begin
                // Full-width compare: only exactly 1 counts as a true flag.
                if (bus.alu_out == DW'(1)) begin
                    pc_in_next = bus.jmp_addr;
                    pc_we_next = 1'b1;
                end
            end else if (bus.alu_op == OP_JNZ) begin
                if (bus.alu_out != '0) begin
                    pc_in_next = bus.jmp_addr;
                    pc_we_next = 1'b1;
                end
            end else if (bus.alu_op == OP_CALL) begin
                if (stack_full) begin
                    ovf_set = 1'b1;
                end else begin
                    push       = 1'b1;
                    sp_next    = sp_reg + SPW'(1);
                    pc_in_next = bus.jmp_addr;
                    pc_we_next = 1'b1;
                end
            end else if (bus.alu_op == OP_RET) begin
                if (stack_empty) begin
                    unf_set = 1'b1;
                end else begin
                    sp_next    = sp_reg - SPW'(1);
                    pc_in_next = top_entry;
                    pc_we_next = 1'b1;
                end
            end
        end

        // A new error on the same edge as err_clr leaves the flag set.
        ovf_next = ovf_set | (ovf_reg & ~bus.err_clr);
        unf_next = unf_set | (unf_reg & ~bus.err_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_in_reg <= '0;
            pc_we_reg <= 1'b0;
            sp_reg    <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            pc_in_reg <= pc_in_next;
            pc_we_reg <= pc_we_next;
            sp_reg    <= sp_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    assign bus.pc_in = pc_in_reg;
    assign bus.pc_we = pc_we_reg;
    assign bus.sp    = sp_reg;
    assign bus.ovf   = ovf_reg;
    assign bus.unf   = unf_reg;
endmodule
